icache_direct_mapped: RTL and testbench

- Direct-mapped, read-only instruction cache between the pipelined datapath fetch stage (upstream) and the memory controller (downstream).
- Serves fetch requests on imemREN/imemaddr and returns ihit/imemload.
- On a miss, fetches one word from the memory controller through the iREN/iaddr/iwait/iload handshake, fills the frame, then serves the hit.
- Maintains hit/miss counters for performance reporting at halt.

---
 rtl/icache_direct_mapped.sv | 99 +++++++++
 tb/tb_icache_direct_mapped.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache between fetch and the memory controller.
// Hits are combinational. A miss fills one word through iREN/iwait, then hits in the following IDLE cycle.
module icache_direct_mapped #(
    parameter int NSETS  = 16,
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              imemREN,
    input  logic [WORD_W-1:0] imemaddr,
    output logic              ihit,
    output logic [WORD_W-1:0] imemload,
    output logic              iREN,
    output logic [WORD_W-1:0] iaddr,
    input  logic              iwait,
    input  logic [WORD_W-1:0] iload,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);
    localparam int IDX_W = $clog2(NSETS);
    localparam int TAG_W = WORD_W - IDX_W - 2;

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state, next_state;
    logic [WORD_W-1:0] miss_addr;
    logic [NSETS-1:0]  valid;
    logic [TAG_W-1:0]  tags [NSETS];
    logic [WORD_W-1:0] data [NSETS];

    logic [IDX_W-1:0]  req_idx, fill_idx;
    logic [TAG_W-1:0]  req_tag, fill_tag;
    logic              miss_start, fill_done;

    assign req_idx  = imemaddr[IDX_W+1:2];
    assign req_tag  = imemaddr[WORD_W-1:IDX_W+2];
    assign fill_idx = miss_addr[IDX_W+1:2];
    assign fill_tag = miss_addr[WORD_W-1:IDX_W+2];

    always_comb begin
        next_state = state;
        ihit       = 1'b0;
        imemload   = '0;
        iREN       = 1'b0;
        iaddr      = '0;
        miss_start = 1'b0;
        fill_done  = 1'b0;
        case (state)
            IDLE: begin
                if (imemREN) begin
                    if (valid[req_idx] && (tags[req_idx] == req_tag)) begin
                        ihit     = 1'b1;
                        imemload = data[req_idx];
                    end else begin
                        miss_start = 1'b1;
                        next_state = FILL;
                    end
                end
            end
            FILL: begin
                iREN  = 1'b1;
                iaddr = miss_addr;
                if (!iwait) begin
                    fill_done  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            miss_addr  <= '0;
            valid      <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state <= next_state;
            if (miss_start) begin
                miss_addr  <= {imemaddr[WORD_W-1:2], imemaddr[1:0] & 2'b00};
                miss_count <= miss_count + 32'd1;
            end
            if (ihit)
                hit_count <= hit_count + 32'd1;
            if (fill_done)
                valid[fill_idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; the valid bits alone qualify them.
    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tags[fill_idx] <= fill_tag;
            data[fill_idx] <= iload;
        end
    end
endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed testbench for icache_direct_mapped; inputs change on the falling edge, outputs are sampled shortly after.
module tb_icache_direct_mapped;
    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int checks = 0;
    int errors = 0;

    icache_direct_mapped #(.NSETS(16), .WORD_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
        .iwait(iwait), .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Stimulus only: miss on addr with immediate iwait=0, then drop the request once the hit appears.
    task automatic do_miss(input logic [31:0] addr, input logic [31:0] word);
        imemREN = 1'b1; imemaddr = addr; iwait = 1'b0; iload = word;
        tick();
        tick();
        imemREN = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0; imemREN = 1'b0; imemaddr = 32'h0; iwait = 1'b1; iload = 32'h0;
        #2;
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL reset_ihit got=%0b exp=0", ihit); end
        checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL reset_iren got=%0b exp=0", iREN); end
        checks++; if (iaddr !== 32'h0 || imemload !== 32'h0) begin errors++; $display("FAIL reset_buses iaddr=%h imemload=%h exp=0", iaddr, imemload); end
        checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin errors++; $display("FAIL reset_counts hit=%0d miss=%0d exp=0", hit_count, miss_count); end
        tick();
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_cold_miss();
        imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b1; iload = 32'h0;
        #1;
        checks++; if (ihit !== 1'b0 || iREN !== 1'b0) begin errors++; $display("FAIL cold_present ihit=%0b iREN=%0b exp=0,0", ihit, iREN); end
        for (int c = 0; c < 3; c++) begin
            tick();
            if (c == 2) begin iwait = 1'b0; iload = 32'h8C220004; end
            #1;
            checks++; if (iREN !== 1'b1 || iaddr !== 32'h40 || ihit !== 1'b0) begin errors++; $display("FAIL cold_fill%0d iREN=%0b iaddr=%h ihit=%0b exp=1,00000040,0", c, iREN, iaddr, ihit); end
        end
        tick();
        iwait = 1'b1;
        #1;
        checks++; if (ihit !== 1'b1 || imemload !== 32'h8C220004) begin errors++; $display("FAIL cold_hit ihit=%0b imemload=%h exp=1,8c220004", ihit, imemload); end
        checks++; if (iREN !== 1'b0 || miss_count !== 32'd1 || hit_count !== 32'd0) begin errors++; $display("FAIL cold_state iREN=%0b miss=%0d hit=%0d exp=0,1,0", iREN, miss_count, hit_count); end
        tick();
        imemREN = 1'b0;
        #1;
        checks++; if (hit_count !== 32'd1 || miss_count !== 32'd1) begin errors++; $display("FAIL cold_counts hit=%0d miss=%0d exp=1,1", hit_count, miss_count); end
    endtask

    task automatic test_ren_low();
        imemREN = 1'b0; imemaddr = 32'h40;
        #1;
        checks++; if (ihit !== 1'b0 || imemload !== 32'h0) begin errors++; $display("FAIL renlow_out ihit=%0b imemload=%h exp=0,0", ihit, imemload); end
        tick();
        checks++; if (hit_count !== 32'd1 || miss_count !== 32'd1) begin errors++; $display("FAIL renlow_counts hit=%0d miss=%0d exp=1,1", hit_count, miss_count); end
    endtask

    task automatic test_warm_hits();
        for (int i = 0; i < 16; i++) do_miss(32'(i * 4), 32'h10000000 + 32'(i * 4));
        for (int i = 0; i < 16; i++) begin
            imemREN = 1'b1; imemaddr = 32'(i * 4);
            #1;
            checks++;
            if (ihit !== 1'b1 || iREN !== 1'b0 || imemload !== 32'h10000000 + 32'(i * 4)) begin
                errors++; $display("FAIL warm_hit%0d ihit=%0b iREN=%0b imemload=%h exp=1,0,%h", i, ihit, iREN, imemload, 32'h10000000 + 32'(i * 4));
            end
            tick();
        end
        imemREN = 1'b0;
        #1;
        checks++; if (hit_count !== 32'd17 || miss_count !== 32'd17) begin errors++; $display("FAIL warm_counts hit=%0d miss=%0d exp=17,17", hit_count, miss_count); end
    endtask

    task automatic test_conflict();
        nRST = 1'b0; #1; nRST = 1'b1;
        do_miss(32'h40, 32'h8C220004);
        imemREN = 1'b1; imemaddr = 32'h440; iwait = 1'b0; iload = 32'h24010001;
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL conflict_miss ihit=%0b exp=0", ihit); end
        tick();
        checks++; if (iREN !== 1'b1 || iaddr !== 32'h440) begin errors++; $display("FAIL conflict_fill iREN=%0b iaddr=%h exp=1,00000440", iREN, iaddr); end
        tick();
        checks++; if (ihit !== 1'b1 || imemload !== 32'h24010001) begin errors++; $display("FAIL conflict_hit ihit=%0b imemload=%h exp=1,24010001", ihit, imemload); end
        imemaddr = 32'h40; iload = 32'h8C220004;
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL conflict_evicted ihit=%0b exp=0", ihit); end
        tick();
        tick();
        checks++; if (ihit !== 1'b1 || imemload !== 32'h8C220004) begin errors++; $display("FAIL conflict_refill ihit=%0b imemload=%h exp=1,8c220004", ihit, imemload); end
        imemREN = 1'b0;
        #1;
        checks++; if (miss_count !== 32'd3 || hit_count !== 32'd0) begin errors++; $display("FAIL conflict_counts miss=%0d hit=%0d exp=3,0", miss_count, hit_count); end
    endtask

    task automatic test_redirect();
        imemREN = 1'b1; imemaddr = 32'h80; iwait = 1'b1; iload = 32'hAAAA0080;
        tick();
        imemaddr = 32'h100;
        #1;
        checks++; if (iREN !== 1'b1 || iaddr !== 32'h80 || ihit !== 1'b0) begin errors++; $display("FAIL redirect_hold iREN=%0b iaddr=%h ihit=%0b exp=1,00000080,0", iREN, iaddr, ihit); end
        tick();
        iwait = 1'b0;
        tick();
        imemaddr = 32'h80;
        #1;
        checks++; if (ihit !== 1'b1 || imemload !== 32'hAAAA0080) begin errors++; $display("FAIL redirect_frame ihit=%0b imemload=%h exp=1,aaaa0080", ihit, imemload); end
        imemaddr = 32'h100; iwait = 1'b1;
        #1;
        checks++; if (ihit !== 1'b0 || iREN !== 1'b0) begin errors++; $display("FAIL redirect_newmiss ihit=%0b iREN=%0b exp=0,0", ihit, iREN); end
        tick();
        checks++; if (iREN !== 1'b1 || iaddr !== 32'h100) begin errors++; $display("FAIL redirect_refetch iREN=%0b iaddr=%h exp=1,00000100", iREN, iaddr); end
        iwait = 1'b0; iload = 32'hBBBB0100;
        tick();
        checks++; if (ihit !== 1'b1 || imemload !== 32'hBBBB0100) begin errors++; $display("FAIL redirect_hit ihit=%0b imemload=%h exp=1,bbbb0100", ihit, imemload); end
        imemREN = 1'b0;
        #1;
        checks++; if (miss_count !== 32'd5 || hit_count !== 32'd0) begin errors++; $display("FAIL redirect_counts miss=%0d hit=%0d exp=5,0", miss_count, hit_count); end
    endtask

    task automatic test_drop_during_fill();
        imemREN = 1'b1; imemaddr = 32'h44; iwait = 1'b1; iload = 32'hCCCC0044;
        tick();
        imemREN = 1'b0;
        #1;
        checks++; if (iREN !== 1'b1 || iaddr !== 32'h44) begin errors++; $display("FAIL drop_fill iREN=%0b iaddr=%h exp=1,00000044", iREN, iaddr); end
        iwait = 1'b0;
        tick();
        imemREN = 1'b1;
        #1;
        checks++; if (ihit !== 1'b1 || imemload !== 32'hCCCC0044) begin errors++; $display("FAIL drop_rerequest ihit=%0b imemload=%h exp=1,cccc0044", ihit, imemload); end
        tick();
        imemREN = 1'b0;
        #1;
        checks++; if (miss_count !== 32'd6 || hit_count !== 32'd1 || iREN !== 1'b0) begin errors++; $display("FAIL drop_counts miss=%0d hit=%0d iREN=%0b exp=6,1,0", miss_count, hit_count, iREN); end
    endtask

    task automatic test_reset_mid_fill();
        imemREN = 1'b1; imemaddr = 32'h48; iwait = 1'b1; iload = 32'hDDDD0048;
        tick();
        #1;
        checks++; if (iREN !== 1'b1) begin errors++; $display("FAIL rstfill_pre iREN=%0b exp=1", iREN); end
        nRST = 1'b0;
        #1;
        checks++; if (iREN !== 1'b0 || ihit !== 1'b0 || iaddr !== 32'h0) begin errors++; $display("FAIL rstfill_async iREN=%0b ihit=%0b iaddr=%h exp=0,0,0", iREN, ihit, iaddr); end
        checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin errors++; $display("FAIL rstfill_counts hit=%0d miss=%0d exp=0,0", hit_count, miss_count); end
        tick();
        nRST = 1'b1; iwait = 1'b0; imemaddr = 32'h44;
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL rstfill_remiss ihit=%0b exp=0", ihit); end
        tick();
        checks++; if (iREN !== 1'b1 || iaddr !== 32'h44 || miss_count !== 32'd1) begin errors++; $display("FAIL rstfill_refetch iREN=%0b iaddr=%h miss=%0d exp=1,00000044,1", iREN, iaddr, miss_count); end
        tick();
        imemREN = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_ren_low();
        test_warm_hits();
        test_conflict();
        test_redirect();
        test_drop_during_fill();
        test_reset_mid_fill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
